mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 32 +++
 rtl/lane_align.sv | 50 +++++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM states
// and the alignment rule used to reject an access before it touches memory.
package mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    STORE,
    DONE
  } state_e;

  // An access is rejected for an illegal size or a lane that straddles
  // its natural alignment boundary.
  function automatic logic access_error(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: access_error = 1'b0;
      SZ_HALF: access_error = addr_lo[0];
      SZ_WORD: access_error = (addr_lo != 2'b00);
      default: access_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane handling: pulls a byte/halfword out of a memory word
// (with optional sign extension) and splices store data into a word.
module lane_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [15:0]       wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [4:0]        shamt;
  logic [15:0]       lane;
  logic [DATA_W-1:0] mask;

  // Aligned accesses only reach here, so the byte offset also locates a halfword.
  assign shamt = {off_i, 3'b000};
  assign lane  = 16'(word_i >> shamt);

  // Extract the addressed lane and extend it to a full word
  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & lane[7]}}, lane[7:0]};
      SZ_HALF: load_o = {{16{signed_i & lane[15]}}, lane};
      default: load_o = word_i;
    endcase
  end

  // Replace the addressed lane of the word with the right-aligned store data
  always_comb begin
    mask    = '0;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        mask    = 32'h0000_00FF << shamt;
        merge_o = (word_i & ~mask) | ({24'h0, wdata_i[7:0]} << shamt);
      end
      SZ_HALF: begin
        mask    = 32'h0000_FFFF << shamt;
        merge_o = (word_i & ~mask) | ({16'h0, wdata_i} << shamt);
      end
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a word-addressed memory. Sub-word
// stores are done as read-modify-write; all outputs are registered.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_in,
  output logic [31:0] mem_select,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out
);

  state_e      state_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_in_q;
  logic [29:0] mem_select_q;
  logic [31:0] mem_data_q;

  logic        req_err;
  logic [31:0] load_word;
  logic [31:0] merge_word;

  assign req_err = access_error(req_size, req_addr[1:0]);

  lane_align u_lane_align (
    .word_i   (mem_out),
    .off_i    (addr_lo_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_word),
    .merge_o  (merge_word)
  );

  // Access FSM; every memory/response output is a register driven from here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_lo_q    <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_in_q     <= 1'b0;
      mem_select_q <= '0;
      mem_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q    <= req_addr[1:0];
            size_q       <= req_size;
            signed_q     <= req_signed;
            wdata_q      <= req_wdata[15:0];
            mem_select_q <= req_addr[31:2];
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            if (req_err) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
            end else if (!req_write) begin
              state_q <= LOAD;
            end else if (req_size == SZ_WORD) begin
              // A full word needs no read, so it goes straight out.
              state_q    <= STORE;
              mem_in_q   <= 1'b1;
              mem_data_q <= req_wdata;
            end else begin
              state_q <= MERGE;
            end
          end
        end
        LOAD: begin
          resp_rdata_q <= load_word;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        MERGE: begin
          mem_data_q <= merge_word;
          mem_in_q   <= 1'b1;
          state_q    <= STORE;
        end
        STORE: begin
          mem_in_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_in     = mem_in_q;
  assign mem_select = {2'b00, mem_select_q};
  assign mem_data   = mem_data_q;

endmodule
